// File: rtl/cordic_pkg.sv
// Shared constants for the vectoring CORDIC family: arctangent table builder,
// inverse gain constant, architecture names and serial controller states.
package cordic_pkg;

    localparam string MODE_SERIAL   = "SERIAL";
    localparam string MODE_PARALLEL = "PARALLEL";

    localparam int ATAN_MAX = 24;

    // 1/K for an unbounded iteration count, Q1.17
    localparam logic [17:0] K_INV = 18'd79594;

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_ITER, S_OUT} ser_state_t;

    // Entry i (32 bits each) is round(atan(2^-i)/pi * 2^width); integer-only so it
    // folds at elaboration. atan is summed as a Taylor series in Q60.
    function automatic logic [ATAN_MAX*32-1:0] atan_tab(input int n, input int width);
        logic [127:0] acc;
        logic [127:0] term;
        logic [127:0] q;
        logic [127:0] pi_q60;
        int           e;
        atan_tab = '0;
        pi_q60   = 128'h3243F6A8885A308D;
        for (int i = 0; i < ATAN_MAX; i++) begin
            if (i < n) begin
                if (i == 0) begin
                    q = 128'd1 << (width - 2);
                end else begin
                    acc = '0;
                    for (int k = 0; k < 40; k++) begin
                        e = i * (2 * k + 1);
                        if (e <= 60) term = (128'd1 << (60 - e)) / 128'(2 * k + 1);
                        else         term = '0;
                        if (k % 2 == 0) acc = acc + term;
                        else            acc = acc - term;
                    end
                    q = ((acc << width) + (pi_q60 >> 1)) / pi_q60;
                end
                atan_tab[i*32 +: 32] = q[31:0];
            end
        end
    endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One combinational vectoring micro-rotation: drives y towards zero and
// accumulates the rotated angle in z.
module cordic_vec_stage #(
    parameter int IW = 20,
    parameter int SW = 4
) (
    input  logic signed [IW-1:0] x,
    input  logic signed [IW-1:0] y,
    input  logic signed [IW-1:0] z,
    input  logic        [SW-1:0] shift,
    input  logic signed [IW-1:0] atan,
    output logic signed [IW-1:0] xo,
    output logic signed [IW-1:0] yo,
    output logic signed [IW-1:0] zo
);

    logic signed [IW-1:0] xs;
    logic signed [IW-1:0] ys;
    logic                 d;

    always_comb begin
        xs = x >>> shift;
        ys = y >>> shift;
        d  = ~y[IW-1];
        xo = d ? x + ys : x - ys;
        yo = d ? y - xs : y + xs;
        zo = d ? z + atan : z - atan;
    end

endmodule

// File: rtl/cordic_mag_ph_pipe.sv
// Vectoring CORDIC magnitude/phase converter, iterative or fully pipelined.
// Phase is scaled so that +pi maps to 2^XY_WIDTH.
module cordic_mag_ph_pipe
    import cordic_pkg::*;
#(
    parameter string CORDIC_TYPE = "SERIAL",
    parameter int    N           = 16,
    parameter int    XY_WIDTH    = 16,
    parameter int    GUARD       = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st,
    input  logic signed [XY_WIDTH-1:0] xin,
    input  logic signed [XY_WIDTH-1:0] yin,
    output logic                       rdy,
    output logic        [XY_WIDTH-1:0] mag,
    output logic signed [XY_WIDTH+1:0] ph
);

    localparam int W  = XY_WIDTH;
    localparam int IW = W + 2 + GUARD;
    localparam int CW = $clog2(N);
    localparam int PW = IW + 19;

    localparam logic [ATAN_MAX*32-1:0] ATAN_ALL = atan_tab(N, W + GUARD);
    localparam logic signed [IW-1:0]   Z_PI     = {2'b01, {(W + GUARD){1'b0}}};
    localparam logic signed [PW-1:0]   MAG_RND  = PW'(2 ** (GUARD + 16));
    localparam logic signed [PW-1:0]   MAG_MAX  = PW'(2 ** W - 1);
    localparam logic signed [IW-1:0]   PH_RND   = IW'((2 ** GUARD) / 2);
    localparam logic signed [IW-1:0]   PH_LIM   = IW'(2 ** W);
    localparam logic signed [W+1:0]    PH_PI    = {2'b01, {W{1'b0}}};

    if (!(CORDIC_TYPE == MODE_SERIAL || CORDIC_TYPE == MODE_PARALLEL)) begin : g_bad_type
        $error("cordic_mag_ph_pipe: CORDIC_TYPE must be SERIAL or PARALLEL");
    end
    if (N < 8 || N > 24 || XY_WIDTH < 8 || XY_WIDTH > 24 || GUARD < 0) begin : g_bad_size
        $error("cordic_mag_ph_pipe: N and XY_WIDTH must lie in 8..24, GUARD >= 0");
    end

    logic signed [IW-1:0] atan_rom [N];
    for (genvar g = 0; g < N; g++) begin : g_rom
        assign atan_rom[g] = IW'(ATAN_ALL[g*32 +: 32]);
    end

    // Pre-rotation folds the left half-plane onto the right so the iterations converge.
    logic signed [W-1:0]  raw_x, raw_y;
    logic signed [IW-1:0] ext_x, ext_y, pre_x, pre_y, pre_z;
    logic                 pre_yz, pre_xn;

    always_comb begin
        ext_x  = IW'(raw_x) <<< GUARD;
        ext_y  = IW'(raw_y) <<< GUARD;
        pre_xn = raw_x[W-1];
        pre_yz = (raw_y == '0);
        if (pre_xn) begin
            pre_x = -ext_x;
            pre_y = -ext_y;
            pre_z = raw_y[W-1] ? -Z_PI : Z_PI;
        end else begin
            pre_x = ext_x;
            pre_y = ext_y;
            pre_z = '0;
        end
    end

    // Output stage: gain compensation with saturation, phase rounding and clamping.
    // y == 0 is resolved exactly, which also pins the x=y=0 case to a zero phase.
    logic signed [IW-1:0] fin_x, fin_z;
    logic                 fin_yz, fin_xn;
    logic signed [PW-1:0] prod, mag_w;
    logic signed [IW-1:0] ph_w;
    logic        [W-1:0]  mag_nxt;
    logic signed [W+1:0]  ph_nxt;

    always_comb begin
        prod  = $signed(PW'(fin_x)) * $signed(PW'(K_INV));
        mag_w = (prod + MAG_RND) >>> (GUARD + 17);
        if (fin_x[IW-1])          mag_nxt = '0;
        else if (mag_w > MAG_MAX) mag_nxt = '1;
        else                      mag_nxt = mag_w[W-1:0];

        ph_w = (fin_z + PH_RND) >>> GUARD;
        if (ph_w > PH_LIM)       ph_w = PH_LIM;
        else if (ph_w < -PH_LIM) ph_w = -PH_LIM;
        if (fin_yz) ph_nxt = fin_xn ? PH_PI : '0;
        else        ph_nxt = ph_w[W+1:0];
    end

    // Handshake: SERIAL accepts st only while rdy is high and holds rdy low until the
    // result lands N+2 edges later; PARALLEL carries st as a valid bit with the data,
    // no backpressure, and rdy is the valid of the output register.
    if (CORDIC_TYPE == MODE_SERIAL) begin : g_serial
        ser_state_t           state;
        logic [CW-1:0]        cnt;
        logic signed [IW-1:0] cx, cy, cz, nx, ny, nz;
        logic                 cyz, cxn;

        cordic_vec_stage #(.IW(IW), .SW(CW)) u_stage (
            .x(cx), .y(cy), .z(cz), .shift(cnt), .atan(atan_rom[cnt]),
            .xo(nx), .yo(ny), .zo(nz)
        );

        assign fin_x  = cx;
        assign fin_z  = cz;
        assign fin_yz = cyz;
        assign fin_xn = cxn;

        always_ff @(posedge clk) begin
            if (reset) begin
                state <= S_IDLE;
                rdy   <= 1'b1;
                mag   <= '0;
                ph    <= '0;
                cnt   <= '0;
            end else begin
                case (state)
                    S_IDLE: if (st) begin
                        raw_x <= xin;
                        raw_y <= yin;
                        rdy   <= 1'b0;
                        state <= S_PRE;
                    end
                    S_PRE: begin
                        cx    <= pre_x;
                        cy    <= pre_y;
                        cz    <= pre_z;
                        cyz   <= pre_yz;
                        cxn   <= pre_xn;
                        cnt   <= '0;
                        state <= S_ITER;
                    end
                    S_ITER: begin
                        cx  <= nx;
                        cy  <= ny;
                        cz  <= nz;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(N - 1)) state <= S_OUT;
                    end
                    default: begin
                        mag   <= mag_nxt;
                        ph    <= ph_nxt;
                        rdy   <= 1'b1;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end else begin : g_parallel
        logic signed [IW-1:0] sx [N+1];
        logic signed [IW-1:0] sy [N+1];
        logic signed [IW-1:0] sz [N+1];
        logic signed [IW-1:0] rx [N];
        logic signed [IW-1:0] ry [N];
        logic signed [IW-1:0] rz [N];
        logic [N:0]           syz, sxn;
        logic [N+1:0]         v;

        for (genvar k = 0; k < N; k++) begin : g_stage
            cordic_vec_stage #(.IW(IW), .SW(CW)) u_stage (
                .x(sx[k]), .y(sy[k]), .z(sz[k]), .shift(CW'(k)), .atan(atan_rom[k]),
                .xo(rx[k]), .yo(ry[k]), .zo(rz[k])
            );
        end

        assign fin_x  = sx[N];
        assign fin_z  = sz[N];
        assign fin_yz = syz[N];
        assign fin_xn = sxn[N];

        always_ff @(posedge clk) begin
            if (reset) begin
                v   <= '0;
                rdy <= 1'b0;
                mag <= '0;
                ph  <= '0;
            end else begin
                v      <= {v[N:0], st};
                raw_x  <= xin;
                raw_y  <= yin;
                sx[0]  <= pre_x;
                sy[0]  <= pre_y;
                sz[0]  <= pre_z;
                syz[0] <= pre_yz;
                sxn[0] <= pre_xn;
                for (int k = 0; k < N; k++) begin
                    sx[k+1]  <= rx[k];
                    sy[k+1]  <= ry[k];
                    sz[k+1]  <= rz[k];
                    syz[k+1] <= syz[k];
                    sxn[k+1] <= sxn[k];
                end
                rdy <= v[N+1];
                if (v[N+1]) begin
                    mag <= mag_nxt;
                    ph  <= ph_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_cordic_mag_ph_pipe.sv
// Directed-vector bench for the SERIAL and PARALLEL builds of cordic_mag_ph_pipe,
// including handshake timing, busy/held strobes and mid-flight reset.
module tb_cordic_mag_ph_pipe;

    localparam int W   = 16;
    localparam int N   = 16;
    localparam int LAT = N + 2;
    localparam int NV  = 10;
    localparam int TOL_MAG = 3;
    localparam int TOL_PH  = 4;

    typedef struct {
        int x;
        int y;
        int mag;
        int ph;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic st_s, st_p;
    logic signed [W-1:0] xin_s, yin_s, xin_p, yin_p;
    logic                rdy_s, rdy_p;
    logic        [W-1:0] mag_s, mag_p;
    logic signed [W+1:0] ph_s, ph_p;

    vec_t tv [NV];
    logic [W-1:0] exp_mag_q[$];
    logic [W+1:0] exp_ph_q[$];
    bit           st_hist[$];
    int           n_chk  = 0;
    int           n_pass = 0;
    int           last_mag, last_ph;

    cordic_mag_ph_pipe #(.CORDIC_TYPE("SERIAL"), .N(N), .XY_WIDTH(W), .GUARD(2)) dut_s (
        .clk(clk), .reset(reset), .st(st_s), .xin(xin_s), .yin(yin_s),
        .rdy(rdy_s), .mag(mag_s), .ph(ph_s)
    );

    cordic_mag_ph_pipe #(.CORDIC_TYPE("PARALLEL"), .N(N), .XY_WIDTH(W), .GUARD(2)) dut_p (
        .clk(clk), .reset(reset), .st(st_p), .xin(xin_p), .yin(yin_p),
        .rdy(rdy_p), .mag(mag_p), .ph(ph_p)
    );

    // clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_near(input string name, input int act, input int exp, input int tol);
        n_chk++;
        if (act - exp <= tol && exp - act <= tol) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (+-%0d)", name, act, exp, tol);
    endtask

    // serial driver tasks
    task automatic ser_start(input int x, input int y);
        @(negedge clk);
        st_s  = 1'b1;
        xin_s = W'(x);
        yin_s = W'(y);
        @(posedge clk);
        #1;
        st_s  = 1'b0;
        xin_s = W'($urandom);
        yin_s = W'($urandom);
    endtask

    task automatic ser_wait(output int lat);
        lat = 0;
        while (!rdy_s && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic ser_run(input int i);
        int lat;
        ser_start(tv[i].x, tv[i].y);
        check_near($sformatf("ser_rdy_fall[%0d]", i), int'(rdy_s), 0, 0);
        ser_wait(lat);
        check_near($sformatf("ser_latency[%0d]", i), lat, LAT, 0);
        check_near($sformatf("ser_mag[%0d]", i), int'(mag_s), tv[i].mag, TOL_MAG);
        check_near($sformatf("ser_ph[%0d]", i), int'(ph_s), tv[i].ph, TOL_PH);
    endtask

    // parallel driver with scoreboard; mode 0 idle, 1 random gaps, 2 every cycle
    task automatic par_cycle(input int mode);
        bit go;
        int k;
        bit exp_rdy;
        @(negedge clk);
        go = (mode == 2) || (mode == 1 && $urandom_range(0, 3) != 0);
        k  = $urandom_range(0, NV - 1);
        st_p  = go;
        xin_p = go ? W'(tv[k].x) : W'($urandom);
        yin_p = go ? W'(tv[k].y) : W'($urandom);
        st_hist.push_back(go);
        if (go) begin
            exp_mag_q.push_back(W'(tv[k].mag));
            exp_ph_q.push_back((W+2)'(tv[k].ph));
        end
        @(posedge clk);
        #1;
        exp_rdy = st_hist.pop_front();
        check_near("par_rdy", int'(rdy_p), int'(exp_rdy), 0);
        if (rdy_p && exp_rdy) begin
            last_mag = int'(exp_mag_q.pop_front());
            last_ph  = int'($signed(exp_ph_q.pop_front()));
            check_near("par_mag", int'(mag_p), last_mag, TOL_MAG);
            check_near("par_ph", int'(ph_p), last_ph, TOL_PH);
        end
    endtask

    task automatic par_restart();
        exp_mag_q.delete();
        exp_ph_q.delete();
        st_hist.delete();
        for (int i = 0; i < LAT; i++) st_hist.push_back(1'b0);
    endtask

    initial begin
        int c;
        int bad;
        bit seen_low;

        tv[0] = '{16384, 0, 16384, 0};
        tv[1] = '{0, 16384, 16384, 32768};
        tv[2] = '{-16384, 0, 16384, 65536};
        tv[3] = '{-32768, -32768, 46341, -49152};
        tv[4] = '{0, 0, 0, 0};
        tv[5] = '{-32768, -1, 32768, -65535};
        tv[6] = '{32767, 32767, 46340, 16384};
        tv[7] = '{10000, -10000, 14142, -16384};
        tv[8] = '{-20000, 15000, 25000, 52112};
        tv[9] = '{30000, -5000, 30414, -3445};

        reset = 1'b1;
        st_s = 1'b0; xin_s = '0; yin_s = '0;
        st_p = 1'b0; xin_p = '0; yin_p = '0;
        repeat (3) @(posedge clk);
        #1;
        check_near("rst_ser_rdy", int'(rdy_s), 1, 0);
        check_near("rst_ser_mag", int'(mag_s), 0, 0);
        check_near("rst_ser_ph", int'(ph_s), 0, 0);
        check_near("rst_par_rdy", int'(rdy_p), 0, 0);
        check_near("rst_par_mag", int'(mag_p), 0, 0);
        check_near("rst_par_ph", int'(ph_p), 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // serial table
        for (int i = 0; i < NV; i++) ser_run(i);

        // strobe while busy is dropped, not queued
        ser_start(16384, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        st_s = 1'b1; xin_s = 16'sd0; yin_s = 16'sd16384;
        @(negedge clk);
        st_s = 1'b0;
        ser_wait(c);
        check_near("busy_rdy", int'(rdy_s), 1, 0);
        check_near("busy_mag", int'(mag_s), 16384, TOL_MAG);
        check_near("busy_ph", int'(ph_s), 0, TOL_PH);
        bad = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (!rdy_s || ph_s != 0) bad++;
        end
        check_near("busy_no_requeue", bad, 0, 0);

        // st held high: first result after 18 edges, then one every 19
        @(negedge clk);
        st_s = 1'b1; xin_s = 16'sd30000; yin_s = -16'sd5000;
        @(posedge clk);
        #1;
        c = 0;
        while (!rdy_s && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        check_near("held_first", c, LAT, 0);
        c = 0;
        seen_low = 1'b0;
        while (c < 100) begin
            @(posedge clk);
            #1;
            c++;
            if (!rdy_s) seen_low = 1'b1;
            if (seen_low && rdy_s) break;
        end
        check_near("held_period", c, LAT + 1, 0);
        check_near("held_mag", int'(mag_s), 30414, TOL_MAG);
        check_near("held_ph", int'(ph_s), -3445, TOL_PH);
        @(negedge clk);
        st_s = 1'b0;
        repeat (2) @(posedge clk);

        // reset during iteration discards the computation
        ser_start(-20000, 15000);
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_near("midrst_rdy", int'(rdy_s), 1, 0);
        check_near("midrst_mag", int'(mag_s), 0, 0);
        check_near("midrst_ph", int'(ph_s), 0, 0);
        reset = 1'b0;
        bad = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (!rdy_s || mag_s != 0) bad++;
        end
        check_near("midrst_quiet", bad, 0, 0);

        // parallel: back-to-back, random gaps, drain
        par_restart();
        repeat (24) par_cycle(2);
        repeat (40) par_cycle(1);
        repeat (LAT + 2) par_cycle(0);
        check_near("par_sb_empty", exp_mag_q.size(), 0, 0);
        repeat (5) par_cycle(0);
        check_near("par_hold_mag", int'(mag_p), last_mag, TOL_MAG);
        check_near("par_hold_ph", int'(ph_p), last_ph, TOL_PH);

        // parallel reset mid-stream, then refill
        repeat (10) par_cycle(2);
        @(negedge clk);
        reset = 1'b1;
        st_p  = 1'b1;
        @(posedge clk);
        #1;
        check_near("par_rst_rdy", int'(rdy_p), 0, 0);
        check_near("par_rst_mag", int'(mag_p), 0, 0);
        check_near("par_rst_ph", int'(ph_p), 0, 0);
        reset = 1'b0;
        par_restart();
        repeat (30) par_cycle(1);
        repeat (LAT + 2) par_cycle(0);
        check_near("par_sb_empty2", exp_mag_q.size(), 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
